// File: rtl/pc_unit_if.sv
// -----------------------------------------------------------------------------
// pc_unit_if
//   Bundles the control-unit / fetch-side signals of the program-counter unit.
//   master : control side (drives requests and target, observes PC and status)
//   slave  : pc_unit (consumes requests, drives PC and status)
//   Signals:
//     Enter            operator switch, asynchronous, level change = one event
//     Input / Output   current instruction is an I/O read / write
//     stall            hold PC and all state this cycle
//     branch_taken     load target
//     jump             load target
//     call             push pc+1, load target
//     ret              pop return address into PC
//     target           branch / jump / call destination
//     pc               registered program counter
//     pc_plus1         combinational pc+1 (wraps)
//     io_waiting       registered, high while waiting for an enter event
//     stack_overflow   sticky, call while stack full
//     stack_underflow  sticky, ret while stack empty
// -----------------------------------------------------------------------------
interface pc_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  Enter;
    logic                  Input;
    logic                  Output;
    logic                  stall;
    logic                  branch_taken;
    logic                  jump;
    logic                  call;
    logic                  ret;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus1;
    logic                  io_waiting;
    logic                  stack_overflow;
    logic                  stack_underflow;

    modport master (
        output Enter, Input, Output, stall, branch_taken, jump, call, ret, target,
        input  pc, pc_plus1, io_waiting, stack_overflow, stack_underflow
    );

    modport slave (
        input  Enter, Input, Output, stall, branch_taken, jump, call, ret, target,
        output pc, pc_plus1, io_waiting, stack_overflow, stack_underflow
    );
endinterface

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
//   Program-counter unit: registers the next PC (sequential, branch, jump,
//   call, return), keeps a hardware return-address stack, honours a pipeline
//   stall and freezes the PC during I/O instructions until the operator
//   toggles the Enter switch.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    pc_unit_if.slave (requests in; pc, pc_plus1, status out)
// -----------------------------------------------------------------------------
module pc_unit #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    STACK_DEPTH  = 4,
    parameter int                    SYNC_STAGES  = 2
) (
    input  logic           clk,
    input  logic           reset,
    pc_unit_if.slave       bus
);

    // sp counts 0..STACK_DEPTH inclusive, so it needs one code beyond the depth
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    localparam logic [ADDR_WIDTH-1:0] PC_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SP_W-1:0]       SP_ONE  = {{(SP_W-1){1'b0}}, 1'b1};
    localparam logic [SP_W-1:0]       SP_ZERO = {SP_W{1'b0}};
    localparam logic [SP_W-1:0]       SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        IO_WAIT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [SP_W-1:0]         sp_q, sp_d;
    logic [ADDR_WIDTH-1:0]   stack_q [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0]   stack_d [STACK_DEPTH];
    logic                    overflow_q, overflow_d;
    logic                    underflow_q, underflow_d;
    logic                    io_waiting_q, io_waiting_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic                    enter_q, enter_d;

    logic                    enter_s;
    logic                    enter_evt_s;
    logic                    io_req_s;
    logic [ADDR_WIDTH-1:0]   pc_plus1_s;
    logic [SP_W-1:0]         sp_dec_s;
    logic [ADDR_WIDTH-1:0]   pop_val_s;

    assign enter_s     = sync_q[SYNC_STAGES-1];
    assign enter_evt_s = enter_s ^ enter_q;
    assign io_req_s    = bus.Input | bus.Output;
    assign pc_plus1_s  = pc_q + PC_ONE;
    assign sp_dec_s    = sp_q - SP_ONE;

    assign bus.pc              = pc_q;
    assign bus.pc_plus1        = pc_plus1_s;
    assign bus.io_waiting      = io_waiting_q;
    assign bus.stack_overflow  = overflow_q;
    assign bus.stack_underflow = underflow_q;

    // Enter synchroniser and edge-detect history; these advance every cycle,
    // even under stall, so toggles seen outside a wait are simply consumed.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], bus.Enter};
        enter_d = enter_s;
    end

    // Top-of-stack read mux (entry sp-1)
    always_comb begin
        pop_val_s = {ADDR_WIDTH{1'b0}};
        for (int i = 0; i < STACK_DEPTH; i++) begin
            pop_val_s = (SP_W'(i) == sp_dec_s) ? stack_q[i] : pop_val_s;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            pc_q         <= RESET_VECTOR;
            sp_q         <= SP_ZERO;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            io_waiting_q <= 1'b0;
            sync_q       <= {SYNC_STAGES{1'b0}};
            enter_q      <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= {ADDR_WIDTH{1'b0}};
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            sp_q         <= sp_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            io_waiting_q <= io_waiting_d;
            sync_q       <= sync_d;
            enter_q      <= enter_d;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (bus.stall) begin
                    state_d = RUN;
                end else if (io_req_s && !enter_evt_s) begin
                    state_d = IO_WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            IO_WAIT: begin
                if (bus.stall) begin
                    state_d = IO_WAIT;
                end else if (enter_evt_s) begin
                    state_d = RUN;
                end else if (!io_req_s) begin
                    // I/O request withdrawn while waiting: abandon the wait
                    state_d = RUN;
                end else begin
                    state_d = IO_WAIT;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // FSM output / datapath logic: next PC, stack and sticky flags
    always_comb begin
        pc_d         = pc_q;
        sp_d         = sp_q;
        stack_d      = stack_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        io_waiting_d = (state_d == IO_WAIT);
        case (state_q)
            RUN: begin
                if (bus.stall) begin
                    pc_d = pc_q;
                end else if (io_req_s) begin
                    // an event already pending lets the I/O instruction retire now
                    if (enter_evt_s) begin
                        pc_d = pc_plus1_s;
                    end else begin
                        pc_d = pc_q;
                    end
                end else if (bus.ret) begin
                    if (sp_q != SP_ZERO) begin
                        pc_d = pop_val_s;
                        sp_d = sp_dec_s;
                    end else begin
                        pc_d        = pc_plus1_s;
                        underflow_d = 1'b1;
                    end
                end else if (bus.call) begin
                    pc_d = bus.target;
                    if (sp_q < SP_FULL) begin
                        for (int i = 0; i < STACK_DEPTH; i++) begin
                            stack_d[i] = (SP_W'(i) == sp_q) ? pc_plus1_s : stack_q[i];
                        end
                        sp_d = sp_q + SP_ONE;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (bus.jump || bus.branch_taken) begin
                    pc_d = bus.target;
                end else begin
                    pc_d = pc_plus1_s;
                end
            end
            IO_WAIT: begin
                if (!bus.stall && enter_evt_s) begin
                    pc_d = pc_plus1_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit
//   Directed testbench for pc_unit with hand-computed expected PC values.
// -----------------------------------------------------------------------------
module tb_pc_unit;

    logic clk;
    logic reset;

    int n_vec;
    int n_miss;

    pc_unit_if #(.ADDR_WIDTH(32)) bus ();

    pc_unit #(
        .ADDR_WIDTH  (32),
        .RESET_VECTOR(32'h0),
        .STACK_DEPTH (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_ctl();
        bus.Input        = 1'b0;
        bus.Output       = 1'b0;
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        bus.jump         = 1'b0;
        bus.call         = 1'b0;
        bus.ret          = 1'b0;
        bus.target       = 32'h0;
    endtask

    task automatic do_jump(input logic [31:0] t);
        bus.jump   = 1'b1;
        bus.target = t;
        tick(1);
        bus.jump   = 1'b0;
    endtask

    task automatic do_call(input logic [31:0] t);
        bus.call   = 1'b1;
        bus.target = t;
        tick(1);
        bus.call   = 1'b0;
    endtask

    task automatic do_ret();
        bus.ret = 1'b1;
        tick(1);
        bus.ret = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        reset    = 1'b1;
        bus.Enter = 1'b0;
        clear_ctl();

        // 1) reset, count, async reset mid-count, count again
        tick(2);
        reset = 1'b0;
        tick(3);
        check("count3", bus.pc, 32'd3);
        #2 reset = 1'b1;
        #1;
        check("rst_pc", bus.pc, 32'd0);
        check("rst_iow", bus.io_waiting, 1'b0);
        check("rst_ovf", bus.stack_overflow, 1'b0);
        check("rst_unf", bus.stack_underflow, 1'b0);
        tick(1);
        reset = 1'b0;
        tick(5);
        check("count5", bus.pc, 32'd5);

        // 2) I/O read wait, released by one Enter toggle
        do_jump(32'd7);
        check("jump7", bus.pc, 32'd7);
        bus.Input = 1'b1;
        tick(10);
        check("wait_pc", bus.pc, 32'd7);
        check("wait_iow", bus.io_waiting, 1'b1);
        bus.Enter = ~bus.Enter;
        tick(2);
        check("sync_lat_pc", bus.pc, 32'd7);
        tick(1);
        check("release_pc", bus.pc, 32'd8);
        check("release_iow", bus.io_waiting, 1'b0);
        bus.Input = 1'b0;

        // 3) toggle in RUN is not remembered
        bus.Enter = ~bus.Enter;
        tick(3);
        check("run_toggle_pc", bus.pc, 32'd11);
        bus.Output = 1'b1;
        tick(5);
        check("out_wait_pc", bus.pc, 32'd11);
        check("out_wait_iow", bus.io_waiting, 1'b1);
        bus.Enter = ~bus.Enter;
        tick(3);
        check("out_rel_pc", bus.pc, 32'd12);
        check("out_rel_iow", bus.io_waiting, 1'b0);
        bus.Output = 1'b0;
        tick(1);
        check("after_out_pc", bus.pc, 32'd13);

        // I/O request withdrawn during wait: back to RUN, pc held that cycle
        bus.Input = 1'b1;
        tick(1);
        check("drop_wait_iow", bus.io_waiting, 1'b1);
        bus.Input = 1'b0;
        tick(1);
        check("drop_pc", bus.pc, 32'd13);
        check("drop_iow", bus.io_waiting, 1'b0);
        tick(1);
        check("drop_next_pc", bus.pc, 32'd14);

        // stall in RUN holds pc
        bus.stall = 1'b1;
        tick(1);
        check("stall_pc", bus.pc, 32'd14);
        bus.stall = 1'b0;

        // 4) nested call / return
        do_jump(32'h10);
        do_call(32'h40);
        check("call1_pc", bus.pc, 32'h40);
        check("call1_sp", dut.sp_q, 3'd1);
        do_call(32'h80);
        check("call2_pc", bus.pc, 32'h80);
        do_ret();
        check("ret1_pc", bus.pc, 32'h41);
        do_ret();
        check("ret2_pc", bus.pc, 32'h11);
        check("ret2_sp", dut.sp_q, 3'd0);

        // 5) overflow on 5th call, underflow on 5th ret (pushes 12,101,201,301)
        do_call(32'h100);
        do_call(32'h200);
        do_call(32'h300);
        do_call(32'h400);
        check("ovf_before", bus.stack_overflow, 1'b0);
        do_call(32'h500);
        check("ovf_pc", bus.pc, 32'h500);
        check("ovf_flag", bus.stack_overflow, 1'b1);
        check("ovf_sp", dut.sp_q, 3'd4);
        bus.ret   = 1'b1;
        bus.stall = 1'b1;
        tick(1);
        bus.stall = 1'b0;
        bus.ret   = 1'b0;
        check("stall_ret_pc", bus.pc, 32'h500);
        do_ret();
        check("pop1", bus.pc, 32'h301);
        do_ret();
        check("pop2", bus.pc, 32'h201);
        do_ret();
        check("pop3", bus.pc, 32'h101);
        do_ret();
        check("pop4", bus.pc, 32'h12);
        check("unf_before", bus.stack_underflow, 1'b0);
        do_ret();
        check("unf_pc", bus.pc, 32'h13);
        check("unf_flag", bus.stack_underflow, 1'b1);
        check("ovf_sticky", bus.stack_overflow, 1'b1);

        // call beats jump in the same cycle
        bus.jump = 1'b1;
        do_call(32'h60);
        bus.jump = 1'b0;
        check("prio_pc", bus.pc, 32'h60);
        check("prio_sp", dut.sp_q, 3'd1);

        // 6) wrap-around, stall overriding jump+branch, reset during wait
        do_jump(32'hFFFF_FFFF);
        check("max_pc", bus.pc, 32'hFFFF_FFFF);
        check("wrap_plus1", bus.pc_plus1, 32'h0);
        tick(1);
        check("wrap_pc", bus.pc, 32'h0);
        bus.jump         = 1'b1;
        bus.branch_taken = 1'b1;
        bus.stall        = 1'b1;
        bus.target       = 32'h55;
        tick(1);
        clear_ctl();
        check("stall_jb_pc", bus.pc, 32'h0);
        do_jump(32'h20);
        bus.Input = 1'b1;
        tick(2);
        check("pre_rst_iow", bus.io_waiting, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("wait_rst_pc", bus.pc, 32'h0);
        check("wait_rst_iow", bus.io_waiting, 1'b0);
        check("wait_rst_sp", dut.sp_q, 3'd0);
        check("wait_rst_unf", bus.stack_underflow, 1'b0);
        tick(1);
        bus.Input = 1'b0;
        reset     = 1'b0;
        tick(1);
        check("post_rst_pc", bus.pc, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
